// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
//
// Issues sequential fetch addresses to a synchronous instruction memory
// (1-cycle read latency), captures {pc, instr} pairs into a small FIFO and
// presents the FIFO head to decode. Decode stalls back-pressure fetch via
// credit accounting; a redirect flushes the FIFO, kills any fetch in flight
// and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   redirect       branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc    redirect target, bits [1:0] ignored
//   stall          decode stall; head is held
//   imem_req       fetch issued this cycle
//   imem_addr      fetch byte address
//   imem_rdata     instruction for the address issued the previous cycle
//   out_valid      head entry valid
//   out_pc         head pc (0 when empty)
//   out_instr      head instruction (0 bubble when empty)
//
// Optional macro FETCH_QUEUE_STATS_EN adds:
//   stat_flushes   saturating count of redirect cycles
//   stat_empty     saturating count of non-reset cycles with out_valid=0

module fetch_queue #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             stall,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]      stat_flushes,
    output logic [15:0]      stat_empty
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W:0]   used;
    logic             issue;
    logic             push;
    logic             pop;

    // The outstanding fetch reserves a slot so its response always fits.
    assign used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue = !reset && !redirect && (used < DEPTH_C);

    // A redirect in the response cycle drops the response along with the FIFO.
    assign push  = inflight && !redirect;
    assign pop   = out_valid && !stall && !redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr]  : '0;
    assign out_instr = out_valid ? ins_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[PC_W-1:2], 2'b00};
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_W'(4);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]  <= inflight_pc;
            ins_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flushes <= '0;
            stat_empty   <= '0;
        end else begin
            if (redirect && (stat_flushes != '1)) begin
                stat_flushes <= stat_flushes + 16'd1;
            end
            if (!out_valid && (stat_empty != '1)) begin
                stat_empty <= stat_empty + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && ({1'b0, count} == DEPTH_C)));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. Memory word at address a holds a; an expected
// pc stream is rebuilt on every reset/redirect and popped each time the DUT
// hands an entry to decode.

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] stat_flushes;
    logic [15:0] stat_empty;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int consumed = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_flushes(stat_flushes),
        .stat_empty  (stat_empty)
`endif
    );

    // Synchronous instruction memory: word at address a is a.
    initial imem_rdata = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {23'b0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Rebuild the expected program-order stream starting at start.
    task automatic expect_from(input logic [8:0] start);
        logic [8:0] p;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(p);
            p = p + 9'd4;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard: every entry consumed by decode must be the next expected pc.
    always @(negedge clk) begin
        if (!reset && out_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", 32'(out_pc), 32'(e));
                chk("pop_instr", out_instr, 32'(e));
                consumed++;
            end
        end
    end

    initial begin
        logic [8:0] exp_addr;
        logic [8:0] head;
        logic       req_pat [6];

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        next_cycle();
        next_cycle();
        mid();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("rst_flushes", 32'(stat_flushes), 32'd0);
        chk("rst_empty", 32'(stat_empty), 32'd0);
`endif

        // Free run: sequential addresses, 2-cycle fill.
        next_cycle();
        reset = 1'b0;
        expect_from(9'h000);
        exp_addr = 9'h000;
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("run_req", 32'(imem_req), 32'd1);
            chk("run_addr", 32'(imem_addr), 32'(exp_addr));
            chk("run_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
            exp_addr = exp_addr + 9'd4;
            next_cycle();
        end

        // Stall 6 cycles from steady state (1 queued + 1 in flight).
        req_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        stall = 1'b1;
        head = exp_q[0];
        for (int c = 0; c < 6; c++) begin
            mid();
            chk("stall_req", 32'(imem_req), 32'(req_pat[c]));
            chk("stall_head", 32'(out_pc), 32'(head));
            next_cycle();
        end
        stall = 1'b0;
        for (int c = 0; c < 8; c++) next_cycle();

        // Fill the queue, then redirect to 0x040.
        stall = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        mid();
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        next_cycle();
        stall = 1'b0;
        redirect = 1'b1;
        redirect_pc = 9'h040;
        expect_from(9'h040);
        mid();
        chk("redir_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
        mid();
        chk("redir1_valid", 32'(out_valid), 32'd0);
        chk("redir1_pc", 32'(out_pc), 32'd0);
        chk("redir1_instr", out_instr, 32'd0);
        chk("redir1_addr", 32'(imem_addr), 32'h040);
        chk("redir1_req", 32'(imem_req), 32'd1);
        next_cycle();
        mid();
        chk("redir2_valid", 32'(out_valid), 32'd0);
        next_cycle();
        mid();
        chk("redir3_valid", 32'(out_valid), 32'd1);
        chk("redir3_pc", 32'(out_pc), 32'h040);
        for (int c = 0; c < 3; c++) next_cycle();

        // Redirect together with stall, unaligned target.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 9'h103;
        expect_from(9'h100);
        next_cycle();
        redirect = 1'b0; stall = 1'b0;
        mid();
        chk("rs_addr", 32'(imem_addr), 32'h100);
        chk("rs_req", 32'(imem_req), 32'd1);
        for (int c = 0; c < 5; c++) next_cycle();

        // Back-to-back redirects: last wins, then wrap past 0x1FC.
        redirect = 1'b1; redirect_pc = 9'h080;
        expect_from(9'h080);
        next_cycle();
        redirect_pc = 9'h1F8;
        expect_from(9'h1F8);
        next_cycle();
        redirect = 1'b0;
        mid();
        chk("b2b_addr", 32'(imem_addr), 32'h1F8);
        next_cycle();
        next_cycle();
        mid();
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        for (int c = 0; c < 7; c++) next_cycle();

        // Reset mid-stream with a fetch in flight.
        mid();
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        next_cycle();
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        mid();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        chk("mrst_pc", 32'(out_pc), 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("mrst_flushes", 32'(stat_flushes), 32'd0);
        chk("mrst_empty", 32'(stat_empty), 32'd0);
`endif
        next_cycle();
        reset = 1'b0;
        expect_from(9'h000);
        mid();
        chk("mrst_addr", 32'(imem_addr), 32'h000);
        next_cycle();
        mid();
        chk("mrst_fill_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < 8; c++) next_cycle();

        mid();
        chk("progress", (consumed >= 20) ? 32'd1 : 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
